binary_quiz_game: RTL and testbench

Timed binary-arithmetic quiz cartridge for the Vericade Logic Lab Arcade, sitting behind the same arcade shell interface as the other games (`btn_pulse`, `sw`, `led`, `grid`, `check_ok`, `score`). An internal LFSR generates pseudo-random operands of parametrised width and an operation. The player enters the answer on the switches and submits. An FSM runs a fixed number of rounds with a per-question timeout, scores correct answers, and drives per-round result feedback on the 8×8 grid.

---
 rtl/binary_quiz_game.sv | 187 ++++++++++++++++++
 tb/tb_binary_quiz_game.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/binary_quiz_game.sv
// Timed binary-arithmetic quiz: LFSR operands, per-question timeout,
// fixed number of rounds, score and grid feedback.
module binary_quiz_game #(
  parameter int          WIDTH         = 4,
  parameter int          ROUNDS        = 8,
  parameter int unsigned TIMEOUT       = 500_000_000,
  parameter int unsigned RESULT_CYCLES = 50_000_000,
  parameter logic [15:0] SEED          = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  btn_pulse,
  input  logic [15:0] sw,
  output logic [15:0] led,
  output logic [63:0] grid,
  output logic        check_ok,
  output logic [7:0]  score
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GEN,
    S_ASK,
    S_RESULT,
    S_DONE
  } state_t;

  localparam logic [1:0]  OP_ADD     = 2'b00;
  localparam logic [1:0]  OP_SUB     = 2'b01;
  localparam logic [1:0]  OP_XOR     = 2'b11;
  localparam logic [1:0]  MODE_MIX   = 2'b10;
  localparam logic [31:0] L_TO_LAST  = 32'(TIMEOUT - 1);
  localparam logic [31:0] L_RES_LAST = 32'(RESULT_CYCLES - 1);
  localparam logic [7:0]  L_ROUNDS   = 8'(ROUNDS);

  state_t           r_state;
  state_t           w_next;
  logic [15:0]      r_lfsr;
  logic [31:0]      r_timer;
  logic [7:0]       r_score;
  logic [7:0]       r_round;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [1:0]       r_op;
  logic             r_correct;
  logic             r_timeout;

  logic             w_start;
  logic             w_submit;
  logic             w_abort;
  logic             w_to_hit;
  logic             w_res_done;
  logic             w_match;
  logic             w_to_result;
  logic             w_new_game;
  logic [1:0]       w_gen_op;
  logic [WIDTH:0]   w_exp;
  logic [7:0]       w_marker;
  logic [7:0]       w_fb;
  logic             w_unused;

  assign w_start    = btn_pulse[0];
  assign w_submit   = btn_pulse[1];
  assign w_abort    = btn_pulse[4];
  assign w_unused   = ^{btn_pulse[3:2], sw[13:WIDTH+1]};
  assign w_to_hit   = (r_timer == L_TO_LAST);
  assign w_res_done = (r_timer == L_RES_LAST);
  assign w_match    = (sw[WIDTH:0] == w_exp);

  assign w_to_result = (r_state == S_ASK) && (w_next == S_RESULT);
  assign w_new_game  = (r_state == S_IDLE || r_state == S_DONE)
                    && (w_next == S_GEN);

  // Mixed mode draws its op from the LFSR MSB at question time
  always_comb begin
    w_gen_op = sw[15:14];
    if (sw[15:14] == MODE_MIX)
      w_gen_op = r_lfsr[15] ? OP_SUB : OP_ADD;
  end

  always_comb begin
    w_exp = '0;
    unique case (r_op)
      OP_ADD:  w_exp = {1'b0, r_a} + {1'b0, r_b};
      OP_SUB:  w_exp = {1'b0, r_a} - {1'b0, r_b};
      default: w_exp = {1'b0, r_a ^ r_b};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_abort && r_state != S_IDLE) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:   if (w_start) w_next = S_GEN;
        S_GEN:    w_next = S_ASK;
        S_ASK:    if (w_submit || w_to_hit) w_next = S_RESULT;
        S_RESULT: if (w_res_done)
                    w_next = (r_round == L_ROUNDS) ? S_DONE : S_GEN;
        S_DONE:   if (w_start) w_next = S_GEN;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr    <= SEED;
      r_timer   <= '0;
      r_score   <= '0;
      r_round   <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_op      <= OP_ADD;
      r_correct <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_lfsr  <= (r_lfsr >> 1) ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
      r_timer <= (w_next == r_state) ? r_timer + 32'd1 : '0;
      if (r_state == S_GEN) begin
        r_a  <= r_lfsr[WIDTH-1:0];
        r_b  <= r_lfsr[8+WIDTH-1:8];
        r_op <= w_gen_op;
      end
      if (w_new_game) begin
        r_score <= '0;
        r_round <= '0;
      end
      // Submit beats a coincident timeout
      if (w_to_result) begin
        r_correct <= w_submit && w_match;
        r_timeout <= !w_submit;
        r_round   <= r_round + 8'd1;
        if (w_submit && w_match && r_score != 8'hFF)
          r_score <= r_score + 8'd1;
      end
    end
  end

  always_comb begin
    w_marker = 8'h04;
    unique case (r_op)
      OP_ADD:  w_marker = 8'h01;
      OP_SUB:  w_marker = 8'h02;
      default: w_marker = 8'h04;
    endcase
    w_fb = 8'h81;
    if (r_correct)
      w_fb = 8'hFF;
    else if (r_timeout)
      w_fb = 8'h18;
  end

  always_comb begin
    led      = {2'b00,
                r_state == S_DONE,
                r_state == S_ASK,
                r_op,
                r_timeout,
                r_correct,
                r_score};
    check_ok = (r_state == S_RESULT) && r_correct;
    score    = r_score;
    grid     = '0;
    unique case (r_state)
      S_ASK, S_RESULT: begin
        grid[63:56] = 8'(r_a);
        grid[55:48] = 8'(r_b);
        grid[47:40] = w_marker;
        grid[7:0]   = 8'(sw[WIDTH:0]);
        if (r_state == S_RESULT)
          grid[39:8] = {4{w_fb}};
      end
      S_DONE:  grid[7:0] = r_score;
      default: grid = '0;
    endcase
  end

endmodule

// File: tb/tb_binary_quiz_game.sv
// Scoreboard bench for binary_quiz_game: a WIDTH=4 short-timer instance
// plus a WIDTH=7 instance for the xor case.
module tb_binary_quiz_game;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  btn = '0;
  logic [4:0]  btn7 = '0;
  logic [15:0] sw = '0;
  logic [15:0] sw7 = '0;
  logic [15:0] led, led7;
  logic [63:0] grid, grid7;
  logic        chk, chk7;
  logic [7:0]  score, score7;

  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  binary_quiz_game #(
    .WIDTH(4), .ROUNDS(3), .TIMEOUT(10),
    .RESULT_CYCLES(4), .SEED(16'hACE1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_pulse(btn), .sw(sw),
    .led(led), .grid(grid), .check_ok(chk), .score(score)
  );

  binary_quiz_game #(
    .WIDTH(7), .ROUNDS(2), .TIMEOUT(20),
    .RESULT_CYCLES(3), .SEED(16'hACE1)
  ) dut7 (
    .clk(clk), .rst_n(rst_n), .btn_pulse(btn7), .sw(sw7),
    .led(led7), .grid(grid7), .check_ok(chk7), .score(score7)
  );

  logic [15:0] m_lfsr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0);
  end

  typedef struct {
    logic       ok;
    logic       to;
    logic [7:0] sc;
    logic [7:0] fb;
  } exp_t;
  exp_t q[$];
  exp_t m_e;

  int g_a, g_b, g_op, g_ans, m_score;
  logic [1:0] g_mode;
  logic prev_ask = 1'b0;

  function automatic int calc(int a, int b, int op, int w);
    int m;
    m = (1 << w) - 1;
    case (op)
      0: return a + b;
      1: return ((a < b) ? (1 << w) : 0) | ((a - b) & m);
      default: return a ^ b;
    endcase
  endfunction

  function automatic int op_of(logic [1:0] mode, logic [15:0] l);
    if (mode == 2'b10) return l[15] ? 1 : 0;
    return int'(mode);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Result monitor: pops the scoreboard on every ASK->RESULT entry
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ask = 1'b0;
    end else begin
      if (prev_ask && !led[12] && grid[47:40] != 8'h00) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL result_unexpected: check_ok=%0b, required none", chk);
        end else begin
          m_e = q.pop_front();
          if (chk !== m_e.ok || led[8] !== m_e.ok || led[9] !== m_e.to ||
              score !== m_e.sc || grid[39:8] !== {4{m_e.fb}}) begin
            n_fail++;
            $display("FAIL result: ok=%0b to=%0b score=%0d rows=%h, required %0b %0b %0d %h",
                     chk, led[9], score, grid[39:8],
                     m_e.ok, m_e.to, m_e.sc, {4{m_e.fb}});
          end
        end
      end
      prev_ask = led[12];
    end
  end

  task automatic wait_ask;
    logic [15:0] last;
    int n;
    n = 0;
    last = m_lfsr;
    while (!led[12] && n < 50) begin
      last = m_lfsr;
      tick;
      n++;
    end
    n_tests++;
    if (!led[12]) begin
      n_fail++;
      $display("FAIL wait_ask: led12=%0b after %0d cycles, required 1", led[12], n);
    end
    g_a = int'(last[3:0]);
    g_b = int'(last[11:8]);
    g_op = op_of(g_mode, last);
    g_ans = calc(g_a, g_b, g_op, 4);
  endtask

  task automatic new_game(input logic [1:0] mode);
    g_mode = mode;
    sw[15:14] = mode;
    btn = 5'h10;
    tick;
    btn = 5'h01;
    tick;
    btn = 5'h00;
    m_score = 0;
    wait_ask;
  endtask

  task automatic submit(input logic ok);
    exp_t e;
    if (ok && m_score < 255) m_score++;
    e.ok = ok;
    e.to = 1'b0;
    e.sc = 8'(m_score);
    e.fb = ok ? 8'hFF : 8'h81;
    q.push_back(e);
    btn = 5'h02;
    tick;
    btn = 5'h00;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) tick;
    n_tests++;
    if (led !== 16'h0 || chk !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_led: led=%h ok=%0b, required 0 0", led, chk);
    end
    n_tests++;
    if (grid !== 64'h0 || score !== 8'h0) begin
      n_fail++;
      $display("FAIL reset_grid: grid=%h score=%0d, required 0 0", grid, score);
    end
    n_tests++;
    if ({led7, grid7, score7, chk7} !== '0) begin
      n_fail++;
      $display("FAIL reset_dut7: led=%h grid=%h, required 0", led7, grid7);
    end
    rst_n = 1'b1;
    new_game(2'b00);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (led !== 16'h0 || grid !== 64'h0 || score !== 8'h0) begin
      n_fail++;
      $display("FAIL reset_mid_ask: led=%h grid=%h score=%0d, required 0 0 0",
               led, grid, score);
    end
    tick;
    rst_n = 1'b1;
    new_game(2'b00);
    n_tests++;
    if (grid[63:56] !== 8'(g_a) || grid[55:48] !== 8'(g_b)) begin
      n_fail++;
      $display("FAIL reset_operands: A=%0d B=%0d, required %0d %0d",
               grid[63:56], grid[55:48], g_a, g_b);
    end
  endtask

  task automatic test_add;
    new_game(2'b00);
    n_tests++;
    if (grid[47:40] !== 8'h01 || led[11:10] !== 2'b00) begin
      n_fail++;
      $display("FAIL add_op: row5=%h op=%0d, required 01 0", grid[47:40], led[11:10]);
    end
    sw[13:0] = 14'(g_ans);
    #1;
    n_tests++;
    if (grid[7:0] !== 8'(g_ans)) begin
      n_fail++;
      $display("FAIL add_row0: row0=%h, required %h", grid[7:0], 8'(g_ans));
    end
    submit(1'b1);
    n_tests++;
    if (score !== 8'(m_score)) begin
      n_fail++;
      $display("FAIL add_score: score=%0d, required %0d", score, m_score);
    end
  endtask

  task automatic test_sub;
    new_game(2'b01);
    n_tests++;
    if (grid[47:40] !== 8'h02 || led[11:10] !== 2'b01) begin
      n_fail++;
      $display("FAIL sub_op: row5=%h op=%0d, required 02 1", grid[47:40], led[11:10]);
    end
    sw[13:0] = 14'(g_ans);
    submit(1'b1);
    wait_ask;
    sw[13:0] = 14'(g_ans ^ 16);
    submit(1'b0);
    n_tests++;
    if (chk !== 1'b0 || led[8] !== 1'b0) begin
      n_fail++;
      $display("FAIL sub_borrow: ok=%0b led8=%0b, required 0 0", chk, led[8]);
    end
  endtask

  task automatic test_mixed;
    new_game(2'b10);
    n_tests++;
    if (led[11:10] !== 2'(g_op)) begin
      n_fail++;
      $display("FAIL mixed_op: op=%0d, required %0d", led[11:10], g_op);
    end
    sw[13:0] = 14'(g_ans);
    submit(1'b1);
  endtask

  task automatic test_timeout;
    exp_t e;
    int n;
    new_game(2'b00);
    e.ok = 1'b0;
    e.to = 1'b1;
    e.sc = 8'(m_score);
    e.fb = 8'h18;
    q.push_back(e);
    n = 1;
    while (n < 40) begin
      tick;
      if (led[12]) n++;
      else break;
    end
    n_tests++;
    if (n != 10) begin
      n_fail++;
      $display("FAIL timeout_len: ask cycles=%0d, required 10", n);
    end
    wait_ask;
    repeat (9) tick;
    sw[13:0] = 14'(g_ans);
    submit(1'b1);
    n_tests++;
    if (led[9] !== 1'b0 || chk !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_tie: led9=%0b ok=%0b, required 0 1", led[9], chk);
    end
  endtask

  task automatic test_mode_abort;
    new_game(2'b00);
    sw[15:14] = 2'b11;
    g_mode = 2'b11;
    tick;
    n_tests++;
    if (led[11:10] !== 2'b00 || grid[47:40] !== 8'h01) begin
      n_fail++;
      $display("FAIL mode_hold: op=%0d row5=%h, required 0 01", led[11:10], grid[47:40]);
    end
    sw[13:0] = 14'(g_ans);
    submit(1'b1);
    wait_ask;
    n_tests++;
    if (led[11:10] !== 2'b11 || grid[47:40] !== 8'h04) begin
      n_fail++;
      $display("FAIL mode_next: op=%0d row5=%h, required 3 04", led[11:10], grid[47:40]);
    end
    sw[13:0] = 14'(g_ans);
    submit(1'b1);
    btn = 5'h10;
    tick;
    btn = 5'h00;
    n_tests++;
    if (grid !== 64'h0 || score !== 8'(m_score) || led[13:12] !== 2'b00) begin
      n_fail++;
      $display("FAIL abort: grid=%h score=%0d st=%b, required 0 %0d 00",
               grid, score, led[13:12], m_score);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    new_game(2'b00);
    sw[13:0] = 14'(g_ans);
    submit(1'b1);
    n = 1;
    while (n < 20) begin
      tick;
      if (grid[47:40] != 8'h00 && !led[12]) n++;
      else break;
    end
    n_tests++;
    if (n != 4) begin
      n_fail++;
      $display("FAIL result_len: cycles=%0d, required 4", n);
    end
    for (int r = 0; r < 2; r++) begin
      wait_ask;
      sw[13:0] = 14'(g_ans);
      submit(1'b1);
    end
    n = 0;
    while (!led[13] && n < 20) begin
      tick;
      n++;
    end
    n_tests++;
    if (led[13] !== 1'b1 || score !== 8'd3 || grid[7:0] !== 8'h03) begin
      n_fail++;
      $display("FAIL done: led13=%0b score=%0d row0=%h, required 1 3 03",
               led[13], score, grid[7:0]);
    end
    n_tests++;
    if (grid[63:8] !== 56'h0 || led[12] !== 1'b0) begin
      n_fail++;
      $display("FAIL done_rows: grid=%h led12=%0b, required 0 0", grid, led[12]);
    end
    btn = 5'h01;
    tick;
    btn = 5'h00;
    tick;
    m_score = 0;
    n_tests++;
    if (led[12] !== 1'b1 || score !== 8'd0) begin
      n_fail++;
      $display("FAIL restart: led12=%0b score=%0d, required 1 0", led[12], score);
    end
  endtask

  task automatic test_xor7;
    logic [15:0] last;
    int a, b, e, n;
    sw7 = {2'b11, 14'h0};
    for (int r = 0; r < 2; r++) begin
      if (r == 0) begin
        btn7 = 5'h01;
        tick;
        btn7 = 5'h00;
      end
      n = 0;
      last = m_lfsr;
      while (!led7[12] && n < 50) begin
        last = m_lfsr;
        tick;
        n++;
      end
      a = int'(last[6:0]);
      b = int'(last[14:8]);
      e = calc(a, b, 3, 7);
      n_tests++;
      if (led7[12] !== 1'b1 || grid7[63:56] !== 8'(a) ||
          grid7[55:48] !== 8'(b) || grid7[47:40] !== 8'h04) begin
        n_fail++;
        $display("FAIL xor7_ask: A=%0d B=%0d row5=%h, required %0d %0d 04",
                 grid7[63:56], grid7[55:48], grid7[47:40], a, b);
      end
      sw7[13:0] = (r == 0) ? 14'(e | 128) : 14'(e);
      btn7 = 5'h02;
      tick;
      btn7 = 5'h00;
      n_tests++;
      if (chk7 !== (r == 1) || score7 !== 8'(r) ||
          grid7[39:8] !== {4{(r == 1) ? 8'hFF : 8'h81}}) begin
        n_fail++;
        $display("FAIL xor7_result%0d: ok=%0b score=%0d rows=%h", r, chk7, score7, grid7[39:8]);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_add;
    test_sub;
    test_mixed;
    test_timeout;
    test_mode_abort;
    test_back_to_back;
    test_xor7;
    repeat (2) tick;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d pending, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
